// File: rtl/branch_pred_pkg.sv
// Shared types and constants for the tagged branch target predictor.
// Counter threshold helpers, the BRANCH opcode, and the table entry layout.
package branch_pred_pkg;

  // Widest tag the entry layout can hold; narrower tags are zero-extended.
  localparam int TAG_MAX = 30;

  // Opcode of conditional branches, used by the ID-side decoder driving upd_valid.
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [31:0]        target;
  } entry_t;

  function automatic int cnt_wt(input int cnt_bits);
    return 1 << (cnt_bits - 1);
  endfunction

  function automatic int cnt_wnt(input int cnt_bits);
    return (1 << (cnt_bits - 1)) - 1;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// Next-value logic for a CNT_BITS saturating up/down counter.
module bp_sat_counter #(
  parameter int CNT_BITS = 2
) (
  input  logic [CNT_BITS-1:0] cnt,
  input  logic                inc,
  output logic [CNT_BITS-1:0] nxt
);

  always_comb begin
    nxt = cnt;
    if (inc) begin
      if (cnt != '1) nxt = cnt + CNT_BITS'(1);
    end else begin
      if (cnt != '0) nxt = cnt - CNT_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Tagged branch target buffer with saturating-counter direction prediction.
// Optional gshare counter indexing is enabled by defining BTP_GSHARE_EN.
module branch_target_predictor
  import branch_pred_pkg::*;
#(
  parameter int N_ENTRIES = 16,
  parameter int IDX_BITS  = $clog2(N_ENTRIES),
  parameter int TAG_BITS  = 8,
  parameter int CNT_BITS  = 2,
  parameter int GHR_BITS  = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [31:0] if_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic        flush
);

  localparam logic [CNT_BITS-1:0] WT  = CNT_BITS'(cnt_wt(CNT_BITS));
  localparam logic [CNT_BITS-1:0] WNT = CNT_BITS'(cnt_wnt(CNT_BITS));

  entry_t              tbl [N_ENTRIES];
  logic [CNT_BITS-1:0] cnt [N_ENTRIES];

  logic [IDX_BITS-1:0] if_idx, upd_idx, if_cidx, upd_cidx;
  logic [TAG_BITS-1:0] if_tag, upd_tag;
  logic                upd_hit;
  logic [CNT_BITS-1:0] cnt_nxt;
  logic                unused_pc;

  assign if_idx  = if_pc[IDX_BITS+1:2];
  assign upd_idx = upd_pc[IDX_BITS+1:2];
  assign if_tag  = if_pc[IDX_BITS+TAG_BITS+1 -: TAG_BITS];
  assign upd_tag = upd_pc[IDX_BITS+TAG_BITS+1 -: TAG_BITS];
  // Low byte-offset bits and bits above the tag take no part in the lookup.
  assign unused_pc = ^{if_pc, upd_pc};

`ifdef BTP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr;

  assign if_cidx  = if_idx ^ IDX_BITS'(ghr);
  assign upd_cidx = upd_idx ^ IDX_BITS'(ghr);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ghr <= '0;
    end else if (flush) begin
      ghr <= '0;
    end else if (upd_valid) begin
      ghr <= (ghr << 1) | GHR_BITS'(upd_taken);
    end
  end
`else
  logic [GHR_BITS-1:0] unused_ghr;

  assign unused_ghr = '0;
  assign if_cidx    = if_idx;
  assign upd_cidx   = upd_idx;
`endif

  // Lookup sees the stored state only; same-cycle updates are not bypassed.
  always_comb begin
    pred_hit    = tbl[if_idx].valid && (tbl[if_idx].tag == TAG_MAX'(if_tag));
    pred_taken  = pred_hit && (cnt[if_cidx] >= WT);
    pred_target = pred_hit ? tbl[if_idx].target : '0;
  end

  assign upd_hit = tbl[upd_idx].valid && (tbl[upd_idx].tag == TAG_MAX'(upd_tag));

  bp_sat_counter #(
    .CNT_BITS (CNT_BITS)
  ) u_sat_counter (
    .cnt (cnt[upd_cidx]),
    .inc (upd_taken),
    .nxt (cnt_nxt)
  );

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tbl[i] <= '0;
        cnt[i] <= WNT;
      end
    end else if (flush) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        tbl[i].valid <= 1'b0;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        cnt[upd_cidx] <= cnt_nxt;
        if (upd_taken) tbl[upd_idx].target <= upd_target;
      end else if (upd_taken) begin
        // Allocate on taken miss, evicting whatever occupied this index.
        tbl[upd_idx].valid  <= 1'b1;
        tbl[upd_idx].tag    <= TAG_MAX'(upd_tag);
        tbl[upd_idx].target <= upd_target;
        cnt[upd_cidx]       <= WT;
      end
    end
  end

endmodule
